riscv_multicycle_core: RTL
==========================

RISCV_MULTICYCLE_CORE -- requirements
Module: riscv_multicycle_core

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter NREGS, default 32, meaning architectural register count; legal values are 16 (RV32E) or 32.
REQ-003 SHALL have parameter MEM_AW, default 10, meaning word-address width of the memory port.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port mem_req, output, 1, memory request valid.
REQ-007 SHALL have port mem_we, output, 1, write enable, qualified by mem_req.
REQ-008 SHALL have port mem_addr, output, MEM_AW, word address, i.e. byte address [MEM_AW+1:2].
REQ-009 SHALL have port mem_wdata, output, 32, store data.
REQ-010 SHALL have port mem_rdata, input, 32, read data, valid in the cycle mem_ready=1.
REQ-011 SHALL have port mem_ready, input, 1, memory completes the current request.
REQ-012 SHALL have port halted, output, 1, core stopped on an illegal instruction or misaligned access.
REQ-013 SHALL have port retire, output, 1, single-cycle pulse when an instruction completes.

Function
REQ-014 SHALL implement an FSM with states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=PC; SHALL hold until mem_ready=1, then latch IR, set PC<=PC+4 and go to DECODE.
REQ-016 DECODE: SHALL read rs1/rs2 into A/B, build the I/S/B/U/J immediate, and compute branch target = oldPC+immB; then go to EXEC, or to HALT if illegal.
REQ-017 Supported ops: LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LW, SW; ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI; ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Any other encoding, or any register index >= NREGS, is illegal.
REQ-018 EXEC: branches SHALL update PC if taken and return to FETCH (3-cycle minimum); LW/SW go to MEM; all other ops go to WB.
REQ-019 JAL/JALR: rd<=oldPC+4; PC<=target; JALR target SHALL have bit 0 cleared.
REQ-020 Shift amount = operand[4:0]; SRA/SRAI SHALL sign-extend; SLT is signed, SLTU unsigned; arithmetic wraps modulo 2^32.
REQ-021 MEM: mem_req=1, mem_addr=ALUOut word, mem_we=1 for SW; SHALL hold all outputs stable until mem_ready. On ready, SW goes to FETCH and LW latches MDR and goes to WB.
REQ-022 Effective address with [1:0]!=0, or a taken jump/branch target with [1:0]!=0, SHALL go to HALT with no memory access and no PC/register update.
REQ-023 WB: SHALL write rd (ALUOut or MDR) and return to FETCH.
REQ-024 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-025 retire SHALL pulse on the last cycle of every completed instruction: branch EXEC, SW MEM-ready, or WB.
REQ-026 HALT: SHALL be terminal until reset; halted=1, mem_req=0, retire=0.
REQ-027 mem_req SHALL be 0 in DECODE, EXEC and WB; mem_ready SHALL be ignored when mem_req=0.

Reset
REQ-028 When reset=1 at a clock edge, the core SHALL go to FETCH with PC=RESET_PC, halted=0, retire=0, mem_req=0 on the next cycle, and all registers cleared to 0; this SHALL apply from any state, including mid-request.
REQ-029 An outstanding memory request aborted by reset SHALL NOT update IR, MDR or any register.

Verification
REQ-030 ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=0xFFFFFFF8, 4 retire pulses.
REQ-031 SW x3,8(x0); LW x5,8(x0) with mem_ready delayed 3 cycles per request -> outputs stable while waiting, word address 2 written with 2, x5=2.
REQ-032 BNE x1,x0,+8 with x1=5 -> PC=old+8; BLTU x2,x1,+8 with x2=0xFFFFFFFD, x1=5 -> not taken; JAL x1,+12 -> x1=old+4.
REQ-033 SRAI x6,x2,1 with x2=0xFFFFFFFD -> 0xFFFFFFFE; SRLI -> 0x7FFFFFFE; ADDI x0,x0,7 -> x0 reads 0.
REQ-034 Word 0xFFFFFFFF fetched, or LW at address 0x6 -> halted=1, no further mem_req; reset -> PC=RESET_PC, fetch resumes.
REQ-035 NREGS=16, ADD x17,x1,x2 -> halted=1; reset asserted during a stalled FETCH -> no IR update and a clean restart.

Source files
------------

// File: rtl/riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multicycle_core
// Brief    : Multicycle RV32I/RV32E integer subset core, single word memory port
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32,
  parameter int          MEM_AW   = 10
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              retire
);
  localparam int         C_RW      = $clog2(NREGS);
  localparam logic [5:0] C_NREGS   = 6'(NREGS);
  localparam logic [2:0] C_FETCH   = 3'd0;
  localparam logic [2:0] C_DECODE  = 3'd1;
  localparam logic [2:0] C_EXEC    = 3'd2;
  localparam logic [2:0] C_MEM     = 3'd3;
  localparam logic [2:0] C_WB      = 3'd4;
  localparam logic [2:0] C_HALT    = 3'd5;
  localparam logic [6:0] C_OP_LUI   = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC = 7'b0010111;
  localparam logic [6:0] C_OP_JAL   = 7'b1101111;
  localparam logic [6:0] C_OP_JALR  = 7'b1100111;
  localparam logic [6:0] C_OP_BR    = 7'b1100011;
  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;
  localparam logic [6:0] C_OP_IMM   = 7'b0010011;
  localparam logic [6:0] C_OP_REG   = 7'b0110011;

  logic [2:0]  r_state;
  logic [31:0] r_pc, r_old_pc, r_ir, r_a, r_b, r_imm, r_btarget, r_alu, r_mdr;
  logic [31:0] r_regs [NREGS];

  logic [6:0]  w_opcode, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_shamt;
  logic [2:0]  w_f3;
  logic        w_is_lui, w_is_auipc, w_is_jal, w_is_jalr, w_is_br, w_is_lw, w_is_sw, w_is_op;
  logic        w_legal, w_use_rd, w_use_rs1, w_use_rs2, w_reg_ok, w_taken, w_fault;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sel;
  logic [31:0] w_alu_b, w_alu, w_ea, w_jump_tgt, w_result;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  assign w_is_lui   = (w_opcode == C_OP_LUI);
  assign w_is_auipc = (w_opcode == C_OP_AUIPC);
  assign w_is_jal   = (w_opcode == C_OP_JAL);
  assign w_is_jalr  = (w_opcode == C_OP_JALR);
  assign w_is_br    = (w_opcode == C_OP_BR);
  assign w_is_lw    = (w_opcode == C_OP_LOAD);
  assign w_is_sw    = (w_opcode == C_OP_STORE);
  assign w_is_op    = (w_opcode == C_OP_REG);

  assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
  assign w_imm_u = {r_ir[31:12], 12'h000};
  assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

  always_comb begin
    w_legal   = 1'b0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      C_OP_LUI, C_OP_AUIPC, C_OP_JAL: begin
        w_legal  = 1'b1;
        w_use_rd = 1'b1;
      end
      C_OP_JALR: begin
        w_legal   = (w_f3 == 3'b000);
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      C_OP_BR: begin
        w_legal   = (w_f3 != 3'b010) && (w_f3 != 3'b011);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      C_OP_LOAD: begin
        w_legal   = (w_f3 == 3'b010);
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      C_OP_STORE: begin
        w_legal   = (w_f3 == 3'b010);
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      C_OP_IMM: begin
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        else                     w_legal = 1'b1;
      end
      C_OP_REG: begin
        w_use_rd  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
        w_legal   = (w_f7 == 7'h00) || ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      default: ;
    endcase
  end

  // Only register fields the format actually uses are range-checked (RV32E).
  assign w_reg_ok = !(w_use_rd  && ({1'b0, w_rd}  >= C_NREGS)) &&
                    !(w_use_rs1 && ({1'b0, w_rs1} >= C_NREGS)) &&
                    !(w_use_rs2 && ({1'b0, w_rs2} >= C_NREGS));

  always_comb begin
    if (w_is_lui || w_is_auipc) w_imm_sel = w_imm_u;
    else if (w_is_jal)          w_imm_sel = w_imm_j;
    else if (w_is_sw)           w_imm_sel = w_imm_s;
    else if (w_is_br)           w_imm_sel = w_imm_b;
    else                        w_imm_sel = w_imm_i;
  end

  assign w_alu_b = w_is_op ? r_b : r_imm;
  assign w_shamt = w_alu_b[4:0];

  always_comb begin
    case (w_f3)
      3'b000:  w_alu = (w_is_op && r_ir[30]) ? (r_a - w_alu_b) : (r_a + w_alu_b);
      3'b001:  w_alu = r_a << w_shamt;
      3'b010:  w_alu = {31'b0, $signed(r_a) < $signed(w_alu_b)};
      3'b011:  w_alu = {31'b0, r_a < w_alu_b};
      3'b100:  w_alu = r_a ^ w_alu_b;
      3'b101:  w_alu = r_ir[30] ? 32'($signed(r_a) >>> w_shamt) : (r_a >> w_shamt);
      3'b110:  w_alu = r_a | w_alu_b;
      default: w_alu = r_a & w_alu_b;
    endcase
  end

  always_comb begin
    case (w_f3)
      3'b000:  w_taken = (r_a == r_b);
      3'b001:  w_taken = (r_a != r_b);
      3'b100:  w_taken = ($signed(r_a) < $signed(r_b));
      3'b101:  w_taken = !($signed(r_a) < $signed(r_b));
      3'b110:  w_taken = (r_a < r_b);
      3'b111:  w_taken = !(r_a < r_b);
      default: w_taken = 1'b0;
    endcase
  end

  assign w_ea       = r_a + r_imm;
  assign w_jump_tgt = w_is_jal ? (r_old_pc + r_imm) : {w_ea[31:1], 1'b0};
  assign w_fault    = ((w_is_jal || w_is_jalr) && (w_jump_tgt[1:0] != 2'b00)) ||
                      (w_is_br && w_taken && (r_btarget[1:0] != 2'b00)) ||
                      ((w_is_lw || w_is_sw) && (w_ea[1:0] != 2'b00));

  always_comb begin
    if (w_is_lui)                   w_result = r_imm;
    else if (w_is_auipc)            w_result = r_old_pc + r_imm;
    else if (w_is_jal || w_is_jalr) w_result = r_pc;
    else if (w_is_lw || w_is_sw)    w_result = w_ea;
    else                            w_result = w_alu;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= C_FETCH;
      r_pc      <= RESET_PC;
      r_old_pc  <= '0;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_btarget <= '0;
      r_alu     <= '0;
      r_mdr     <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        C_FETCH: if (mem_ready) begin
          r_ir     <= mem_rdata;
          r_old_pc <= r_pc;
          r_pc     <= r_pc + 32'd4;
          r_state  <= C_DECODE;
        end
        C_DECODE: begin
          r_a       <= r_regs[w_rs1[C_RW-1:0]];
          r_b       <= r_regs[w_rs2[C_RW-1:0]];
          r_imm     <= w_imm_sel;
          r_btarget <= r_old_pc + w_imm_b;
          r_state   <= (w_legal && w_reg_ok) ? C_EXEC : C_HALT;
        end
        C_EXEC: begin
          if (w_fault) begin
            r_state <= C_HALT;
          end else if (w_is_br) begin
            if (w_taken) r_pc <= r_btarget;
            r_state <= C_FETCH;
          end else begin
            r_alu <= w_result;
            if (w_is_jal || w_is_jalr) r_pc <= w_jump_tgt;
            r_state <= (w_is_lw || w_is_sw) ? C_MEM : C_WB;
          end
        end
        C_MEM: if (mem_ready) begin
          if (w_is_lw) begin
            r_mdr   <= mem_rdata;
            r_state <= C_WB;
          end else begin
            r_state <= C_FETCH;
          end
        end
        C_WB: begin
          if (w_rd[C_RW-1:0] != '0) r_regs[w_rd[C_RW-1:0]] <= w_is_lw ? r_mdr : r_alu;
          r_state <= C_FETCH;
        end
        C_HALT:  r_state <= C_HALT;
        default: r_state <= C_HALT;
      endcase
    end
  end

  // Reset masks requests combinationally so an in-flight handshake is dropped.
  assign mem_req   = !reset && ((r_state == C_FETCH) || (r_state == C_MEM));
  assign mem_we    = mem_req && (r_state == C_MEM) && w_is_sw;
  assign mem_addr  = (r_state == C_MEM) ? r_alu[MEM_AW+1:2] : r_pc[MEM_AW+1:2];
  assign mem_wdata = r_b;
  assign halted    = (r_state == C_HALT);
  assign retire    = !reset && (((r_state == C_EXEC) && w_is_br && !w_fault) ||
                                ((r_state == C_MEM) && w_is_sw && mem_ready) ||
                                (r_state == C_WB));

endmodule
`default_nettype wire
